btn_led_ctrl: RTL

Button-driven LED mode controller for the board's push-button/LED pair. It synchronizes and debounces the raw button, then produces one-cycle press events and a logic-analyzer trigger. A mode state machine (OFF → ON → SLOW blink → FAST blink) is advanced by short presses and forced to OFF by a long press, and the block drives the active-low LED pin. It replaces direct toggling of the LED on the raw button edge.

---
 rtl/btn_led_ctrl_pkg.sv | 36 +++
 rtl/btn_led_ctrl_if.sv | 20 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/btn_led_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/btn_led_ctrl_pkg.sv
// btn_led_ctrl_pkg
//   Shared definitions for the push-button / LED blocks: mode encodings,
//   default timing constants (27 MHz board clock) and small helpers.
//   No ports (package).
package btn_led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 270000;    // 10 ms
  localparam int unsigned DEF_SLOW_HALF         = 13500000;  // 0.5 s
  localparam int unsigned DEF_FAST_HALF         = 3375000;   // 125 ms
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 27000000;  // 1 s

  // Width able to hold 0..n inclusive (never zero bits).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Short-press sequence OFF -> ON -> SLOW -> FAST -> OFF.
  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    case (m)
      MODE_OFF:  r = MODE_ON;
      MODE_ON:   r = MODE_SLOW;
      MODE_SLOW: r = MODE_FAST;
      default:   r = MODE_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_led_ctrl_if.sv
// btn_led_ctrl_if
//   Button / LED pin bundle of the LED mode controller.
//   i_btn     : raw button, 1 = pressed (driven by the board side)
//   o_led     : LED pin, active-low
//   o_mode    : current mode
//   o_press   : one-cycle accepted-press pulse
//   o_trigger : one-cycle press-or-long-press pulse (logic analyzer)
//   master = board / stimulus side, slave = controller.
interface btn_led_ctrl_if;
  import btn_led_ctrl_pkg::*;

  logic  i_btn;
  logic  o_led;
  mode_t o_mode;
  logic  o_press;
  logic  o_trigger;

  modport master (output i_btn, input o_led, o_mode, o_press, o_trigger);
  modport slave  (input i_btn, output o_led, o_mode, o_press, o_trigger);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchronizer plus counter debouncer for one raw button.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset
//   i_btn  : raw asynchronous button
//   btn_db : debounced level
//   rise   : one-cycle pulse, high the cycle after btn_db goes 0 -> 1
module btn_debounce
  import btn_led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic btn_db,
  output logic rise
);

  localparam int unsigned CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          btn_s;
  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_p0 <= 1'b0;
      btn_s   <= 1'b0;
      btn_db  <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_p0 <= i_btn;
      btn_s   <= sync_p0;
      rise    <= 1'b0;
      // Any cycle of agreement restarts the stability window, so a
      // glitch shorter than DEBOUNCE_CYCLES never reaches TERM.
      if (btn_s == btn_db) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        btn_db <= btn_s;
        rise   <= btn_s;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_led_ctrl.sv
// btn_led_ctrl
//   Button-driven LED mode controller: debounced presses step the mode
//   OFF -> ON -> SLOW -> FAST -> OFF, a long hold forces OFF, and the
//   active-low LED is lit, dark, or blinked at the mode's half-period.
//   i_clk : clock (all logic on rising edge)
//   i_rst : asynchronous active-high reset
//   bus   : slave side of btn_led_ctrl_if (i_btn in; o_led, o_mode,
//           o_press, o_trigger out)
module btn_led_ctrl
  import btn_led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned SLOW_HALF         = DEF_SLOW_HALF,
  parameter int unsigned FAST_HALF         = DEF_FAST_HALF,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic           i_clk,
  input  logic           i_rst,
  btn_led_ctrl_if.slave  bus
);

  localparam int unsigned HW = cnt_w(LONG_PRESS_CYCLES);
  localparam int unsigned BLINK_MAX = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
  localparam int unsigned BW = cnt_w(BLINK_MAX);

  logic          btn_db;
  logic          btn_rise;
  logic [HW-1:0] hold_cnt;
  logic          long_evt;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] half_m1;
  logic          phase;
  logic          lit;
  mode_t         mode;
  logic          led;
  logic          press;
  logic          trigger;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (bus.i_btn),
    .btn_db (btn_db),
    .rise   (btn_rise)
  );

  // Hold counter saturates at LONG_PRESS_CYCLES; the long event fires on
  // the edge that brings it there, so exactly once per hold.
  assign long_evt = btn_db && (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_cnt <= '0;
    end else if (!btn_db) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HW'(LONG_PRESS_CYCLES)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  always_comb begin
    half_m1 = (mode == MODE_SLOW) ? BW'(SLOW_HALF - 1) : BW'(FAST_HALF - 1);
    lit     = (mode == MODE_ON) ||
              (((mode == MODE_SLOW) || (mode == MODE_FAST)) && !phase);
  end

  // Mode FSM with registered outputs; blink state restarts (lit) on
  // every mode event so each blinking mode begins with a full lit half.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode      <= MODE_OFF;
      press     <= 1'b0;
      trigger   <= 1'b0;
      led       <= 1'b1;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      press   <= btn_rise;
      trigger <= btn_rise | long_evt;
      led     <= ~lit;
      if (btn_rise) begin
        mode      <= next_mode(mode);
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (long_evt) begin
        mode      <= MODE_OFF;
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if ((mode == MODE_SLOW) || (mode == MODE_FAST)) begin
        if (blink_cnt == half_m1) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end
    end
  end

  assign bus.o_led     = led;
  assign bus.o_mode    = mode;
  assign bus.o_press   = press;
  assign bus.o_trigger = trigger;

endmodule
